// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one single-path delay-feedback FFT stage: tracks the
// sample index, drives butterfly/output/twiddle strobes. Optional SDF_CTRL_ERR_EN enables protocol-error detection.
module sdf_stage_ctrl #(
  parameter int LOG_N = 6,
  parameter int LOG_D = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  output logic             bf_en,
  output logic             do_en,
  output logic             do_start,
  output logic             tw_en,
  output logic [LOG_N-2:0] tw_addr,
  output logic             busy,
  output logic             err
);

  localparam int N    = 1 << LOG_N;
  localparam int D    = 1 << LOG_D;
  localparam int DW   = (LOG_D > 0) ? LOG_D : 1;
  localparam int TW_W = LOG_N - 1;
  localparam int SH   = LOG_N - 1 - LOG_D;

  localparam logic [LOG_N-1:0] CNT_LAST  = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] CNT_D     = LOG_N'(D);
  localparam logic [DW-1:0]    DCNT_LAST = DW'(D - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LOG_N-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic              primed_q, primed_d;
  logic [DW-1:0]     j;

`ifdef SDF_CTRL_ERR_EN
  logic              err_q, err_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      primed_q <= 1'b0;
`ifdef SDF_CTRL_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      primed_q <= primed_d;
`ifdef SDF_CTRL_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    primed_d = primed_q;
`ifdef SDF_CTRL_ERR_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (di_en) begin
          cnt_d    = LOG_N'(1);
          primed_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (di_en) begin
          // cnt wraps to zero here only on the last sample of the frame
          cnt_d = cnt_q + LOG_N'(1);
          if (cnt_q[LOG_D]) primed_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end
        end else begin
`ifdef SDF_CTRL_ERR_EN
          err_d   = 1'b1;
          state_d = IDLE;
`endif
        end
      end
      DRAIN: begin
        if (dcnt_q == '0 && di_en) begin
          cnt_d    = LOG_N'(1);
          primed_d = 1'b1;
          state_d  = RUN;
        end else begin
          if (dcnt_q == DCNT_LAST) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
`ifdef SDF_CTRL_ERR_EN
          if (di_en) err_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bf_en    = 1'b0;
    do_en    = 1'b0;
    do_start = 1'b0;
    tw_en    = 1'b0;
    j        = '0;
    case (state_q)
      RUN: begin
        bf_en    = di_en & cnt_q[LOG_D];
        do_en    = di_en & (cnt_q[LOG_D] | primed_q);
        tw_en    = di_en & primed_q & ~cnt_q[LOG_D];
        do_start = di_en && (cnt_q == CNT_D);
        if (LOG_D > 0) j = cnt_q[DW-1:0];
      end
      DRAIN: begin
        do_en = 1'b1;
        tw_en = 1'b1;
        j     = dcnt_q;
      end
      default: ;
    endcase
    tw_addr = tw_en ? (TW_W'(j) << SH) : '0;
  end

  assign busy = (state_q != IDLE);

`ifdef SDF_CTRL_ERR_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed scoreboard bench for sdf_stage_ctrl: default instance (N=64, D=32)
// plus a LOG_D=3 instance; expectations come from a frame-timeline model.
module tb_sdf_stage_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic di0   = 1'b0;
  logic di3   = 1'b0;

  always #5 clock = ~clock;

  logic       bf0, doe0, dst0, tw0, busy0, err0;
  logic [4:0] addr0;
  logic       bf3, doe3, dst3, tw3, busy3, err3;
  logic [4:0] addr3;

  sdf_stage_ctrl u_dut (
    .clock(clock), .reset(reset), .di_en(di0),
    .bf_en(bf0), .do_en(doe0), .do_start(dst0), .tw_en(tw0),
    .tw_addr(addr0), .busy(busy0), .err(err0)
  );

  sdf_stage_ctrl #(.LOG_N(6), .LOG_D(3)) u_dut3 (
    .clock(clock), .reset(reset), .di_en(di3),
    .bf_en(bf3), .do_en(doe3), .do_start(dst3), .tw_en(tw3),
    .tw_addr(addr3), .busy(busy3), .err(err3)
  );

  typedef struct packed {
    logic       bf;
    logic       doe;
    logic       dst;
    logic       tw;
    logic [4:0] addr;
    logic       busy;
    logic       err;
  } outs_t;

  outs_t obs0, obs3;
  assign obs0 = {bf0, doe0, dst0, tw0, addr0, busy0, err0};
  assign obs3 = {bf3, doe3, dst3, tw3, addr3, busy3, err3};

`ifdef SDF_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  outs_t sb[$];
  int vectors = 0;
  int fails   = 0;

  // Expected outputs k cycles after index 0 of the first of nfr contiguous frames.
  function automatic outs_t exp_run(int k, int nfr, int ld, logic errv);
    outs_t e;
    int n, d, sh, idx, fr, dd;
    logic bf, primed;
    n  = 64;
    d  = 1 << ld;
    sh = 5 - ld;
    e  = '0;
    e.err = errv;
    if (k <= 0) return e;
    if (k < nfr * n) begin
      idx    = k % n;
      fr     = k / n;
      bf     = ((idx >> ld) & 1) != 0;
      primed = (fr > 0) || (idx > d);
      e.busy = 1'b1;
      e.bf   = bf;
      e.doe  = bf | primed;
      e.tw   = primed & ~bf;
      e.dst  = (idx == d);
      e.addr = e.tw ? 5'((idx % d) << sh) : 5'd0;
    end else if (k < nfr * n + d) begin
      dd     = k - nfr * n;
      e.busy = 1'b1;
      e.doe  = 1'b1;
      e.tw   = 1'b1;
      e.addr = 5'(dd << sh);
    end
    return e;
  endfunction

  task automatic chk(string tag, string fld, logic [4:0] got, logic [4:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s %s observed=%0d expected=%0d", tag, fld, got, exp);
    end
  endtask

  task automatic step(int sel, logic di, logic rst, bit cmp, outs_t e, string tag);
    outs_t o, x;
    @(posedge clock);
    #1;
    reset = rst;
    di0   = (sel == 0) ? di : 1'b0;
    di3   = (sel == 3) ? di : 1'b0;
    if (cmp) sb.push_back(e);
    @(negedge clock);
    if (cmp) begin
      x = sb.pop_front();
      o = (sel == 3) ? obs3 : obs0;
      chk(tag, "bf_en",    5'(o.bf),   5'(x.bf));
      chk(tag, "do_en",    5'(o.doe),  5'(x.doe));
      chk(tag, "do_start", 5'(o.dst),  5'(x.dst));
      chk(tag, "tw_en",    5'(o.tw),   5'(x.tw));
      chk(tag, "tw_addr",  o.addr,     x.addr);
      chk(tag, "busy",     5'(o.busy), 5'(x.busy));
      chk(tag, "err",      5'(o.err),  5'(x.err));
    end
  endtask

  initial begin
    outs_t z, e;
    int k;
    z = '0;

    step(0, 1'b0, 1'b1, 1'b0, z, "rst");
    step(0, 1'b0, 1'b1, 1'b0, z, "rst");
    step(0, 1'b0, 1'b0, 1'b1, z, "reset_d0");
    step(3, 1'b0, 1'b0, 1'b1, z, "reset_d3");

    for (int i = 0; i < 100; i++)
      step(0, i < 64, 1'b0, 1'b1, exp_run(i, 1, 5, 1'b0), $sformatf("single k=%0d", i));

    for (int i = 0; i < 164; i++)
      step(0, i < 128, 1'b0, 1'b1, exp_run(i, 2, 5, 1'b0), $sformatf("b2b k=%0d", i));

    for (int i = 0; i < 76; i++)
      step(3, i < 64, 1'b0, 1'b1, exp_run(i, 1, 3, 1'b0), $sformatf("d8 k=%0d", i));

    for (int i = 0; i <= 40; i++)
      step(0, 1'b1, i == 40, 1'b1, exp_run(i, 1, 5, 1'b0), $sformatf("midrst k=%0d", i));
    step(0, 1'b0, 1'b0, 1'b1, z, "after_midrst");
    for (int i = 0; i < 100; i++)
      step(0, i < 64, 1'b0, 1'b1, exp_run(i, 1, 5, 1'b0), $sformatf("fresh k=%0d", i));

    // di_en dropped at index 10
    for (int c = 0; c < 10; c++)
      step(0, 1'b1, 1'b0, 1'b1, exp_run(c, 1, 5, 1'b0), $sformatf("gap c=%0d", c));
    e = '0;
    e.busy = 1'b1;
    step(0, 1'b0, 1'b0, 1'b1, e, "gap_drop");
    if (ERR_EN) begin
      e = '0;
      e.err = 1'b1;
      for (int c = 0; c < 5; c++)
        step(0, 1'b0, 1'b0, 1'b1, e, $sformatf("err_hold c=%0d", c));
      step(0, 1'b0, 1'b1, 1'b1, e, "err_rst");
      step(0, 1'b0, 1'b0, 1'b1, z, "err_clr");
    end else begin
      for (int c = 11; c < 101; c++) begin
        k = c - 1;
        step(0, k < 64, 1'b0, 1'b1, exp_run(k, 1, 5, 1'b0), $sformatf("gap c=%0d", c));
      end
    end

    // stray di_en at drain dcnt=5
    for (int i = 0; i < 100; i++)
      step(0, (i < 64) || (i == 69), 1'b0, 1'b1,
           exp_run(i, 1, 5, ERR_EN && (i >= 70)), $sformatf("stray k=%0d", i));
    e = '0;
    e.err = ERR_EN;
    step(0, 1'b0, 1'b1, 1'b1, e, "final_rst");
    step(0, 1'b0, 1'b0, 1'b1, z, "final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
